// File: rtl/regfile_pkg.sv
// Shared register-file constants for the 0dMIPS datapath.
// The decode and writeback stages reuse these constants.
package regfile_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/dff_register.sv
// One word of D flip-flops sharing clock, asynchronous reset and a load enable.
module dff_register
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile.sv
// 2-read / 1-write register file with hardwired-zero r0 and optional write-to-read bypass.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_WIDTH,
  parameter int unsigned DEPTH  = REG_COUNT,
  parameter bit          BYPASS = 1'b0,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] W_addr,
  input  logic [WIDTH-1:0]  W_data,
  input  logic [ADDR_W-1:0] A_addr,
  output logic [WIDTH-1:0]  A_data,
  input  logic [ADDR_W-1:0] B_addr,
  output logic [WIDTH-1:0]  B_data
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0]            wr_sel;
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        wr_live;

  assign wr_live = wr_enable && !rst && (W_addr != ZeroAddr);

  // One-hot write decode; r0 never gets an enable.
  always_comb begin
    wr_sel = '0;
    if (wr_live) begin
      wr_sel[W_addr] = 1'b1;
    end
  end

  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    dff_register #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (wr_sel[i]),
      .d_i  (W_data),
      .q_o  (regs[i])
    );
  end

  always_comb begin
    A_data = regs[A_addr];
    B_data = regs[B_addr];
    if (BYPASS && wr_live && (A_addr == W_addr)) begin
      A_data = W_data;
    end
    if (BYPASS && wr_live && (B_addr == W_addr)) begin
      B_data = W_data;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: one instance without and one with bypass, shared stimulus.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_enable = 1'b0;
  logic [4:0]  W_addr = '0;
  logic [31:0] W_data = '0;
  logic [4:0]  A_addr = '0;
  logic [4:0]  B_addr = '0;
  logic [31:0] A_data, B_data, A_data_byp, B_data_byp;

  always #5 clk = ~clk;

  regfile #(
    .WIDTH  (32),
    .DEPTH  (32),
    .BYPASS (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_enable (wr_enable),
    .W_addr    (W_addr),
    .W_data    (W_data),
    .A_addr    (A_addr),
    .A_data    (A_data),
    .B_addr    (B_addr),
    .B_data    (B_data)
  );

  regfile #(
    .WIDTH  (32),
    .DEPTH  (32),
    .BYPASS (1'b1)
  ) dut_byp (
    .clk       (clk),
    .rst       (rst),
    .wr_enable (wr_enable),
    .W_addr    (W_addr),
    .W_data    (W_data),
    .A_addr    (A_addr),
    .A_data    (A_data_byp),
    .B_addr    (B_addr),
    .B_data    (B_data_byp)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] a_byp;
    logic [31:0] b_byp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", nm, act, expv);
    end
  endtask

  // Monitor: inputs are stable and combinational reads settled by the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, " A"}, A_data, e.a);
      check({e.name, " B"}, B_data, e.b);
      check({e.name, " A_byp"}, A_data_byp, e.a_byp);
      check({e.name, " B_byp"}, B_data_byp, e.b_byp);
    end
  end

  // One step per clock: commit the previous cycle's write to the model, drive new inputs,
  // queue the reads expected during this cycle.
  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] aa, input logic [4:0] ba,
                      input string nm);
    exp_t e;
    logic fwd;
    @(posedge clk);
    if (wr_enable && !rst && W_addr != 5'd0) model[W_addr] = W_data;
    #1;
    rst = r; wr_enable = we; W_addr = wa; W_data = wd; A_addr = aa; B_addr = ba;
    if (r) foreach (model[k]) model[k] = 32'd0;
    fwd = !r && we && (wa != 5'd0);
    e.name  = nm;
    e.a     = r ? 32'd0 : model[aa];
    e.b     = r ? 32'd0 : model[ba];
    e.a_byp = (fwd && aa == wa) ? wd : e.a;
    e.b_byp = (fwd && ba == wa) ? wd : e.b;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [4:0] aa, input logic [4:0] ba, input string nm);
    step(1'b0, 1'b0, 5'd0, 32'd0, aa, ba, nm);
  endtask

  initial begin
    foreach (model[k]) model[k] = 32'd0;
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd9, "reset_held");
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), "reset_sweep");

    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "wr5_same_cycle");
    rd(5'd5, 5'd5, "rd5");
    rd(5'd4, 5'd6, "rd4_6");

    step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, "wr0_same_cycle");
    rd(5'd0, 5'd5, "rd0");

    step(1'b0, 1'b1, 5'd7, 32'h1, 5'd7, 5'd0, "wr7_one");
    step(1'b0, 1'b0, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd7, "hold7");
    rd(5'd7, 5'd7, "hold7_after");
    step(1'b0, 1'b1, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd7, "wr7_before_edge");
    rd(5'd7, 5'd7, "wr7_after_edge");

    for (int i = 1; i < 32; i++)
      step(1'b0, 1'b1, 5'(i), 32'(i), 5'(i - 1), 5'(i), "fill_index");
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(i ^ 1), "fill_sweep");
    step(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd31, "rst_pulse_wr_lost");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd31, "post_rst");
    step(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd1, "first_wr_after_rst");
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), "post_rst_sweep");

    for (int i = 1; i < 32; i++)
      step(1'b0, 1'b1, 5'(i), $urandom(), 5'(i - 1), 5'(i), "b2b_write");
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), "b2b_sweep");

    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
           $urandom(), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "random");

    rd(5'd0, 5'd0, "final");
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the 0dMIPS datapath: 32 × 32-bit registers, two combinational read ports and one write port committing on the rising clock edge. Each register is a word of master-slave D flip-flops sharing the global clock and asynchronous reset. It sits between the decode stage (register addresses) and the ALU operand muxes, and takes writeback data from the memory/ALU result mux.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 32, number of registers; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), register address width; derived, not overridden
- BYPASS, 0, 1 = same-cycle write data is forwarded to a read port addressing the register being written
- clk  input  1  clock; writes commit on the rising edge
- rst  input  1  reset, asynchronous and active-high; clears every register to 0
- wr_enable  input  1  write strobe for W_addr/W_data
- W_addr  input  ADDR_W  write register index
- W_data  input  WIDTH  write data
- A_addr  input  ADDR_W  read port A index
- A_data  output  WIDTH  read port A data
- B_addr  input  ADDR_W  read port B index
- B_data  output  WIDTH  read port B data

## Operation
- Register 0 is hardwired zero: no storage; writes to it are ignored; reads always return 0, with or without BYPASS.
- Write: on rising clk with wr_enable=1, rst=0, W_addr≠0, register[W_addr] ← W_data; all other registers hold. wr_enable=0: every register holds.
- Write decode: one-hot decoder of W_addr gated by wr_enable drives each register's enable; at most one register enabled per cycle.
- Read: A_data = register[A_addr], B_data = register[B_addr], purely combinational; A and B are independent and may select the same register.
- BYPASS=1: if wr_enable=1, W_addr≠0 and A_addr==W_addr, A_data = W_data (likewise for B); otherwise stored value. BYPASS=0: reads show the pre-edge value until the edge commits.
- Reset: rst=1 clears all registers immediately, independent of clk; A_data/B_data read 0 for every address while rst=1 (BYPASS also suppressed while rst=1). Writes ignored while rst=1.

## Timing
- Reset value of outputs: A_data = 0, B_data = 0.
- Write latency: 1 edge; data written at edge N is visible on read ports after edge N (same cycle only via BYPASS).
- Read latency: 0 cycles (address → data combinational).
- Simultaneous read and write of the same register, BYPASS=0: read returns old value before the edge, new value after.
- rst asserted mid-cycle with a pending write: write lost, register reads 0. rst deasserted: first write takes effect at the first rising edge with rst=0.
- Enable, address and data must be stable around the rising edge; the flip-flop master captures during clk low.

## Structure
- Shared package: WORD_WIDTH=32, REG_COUNT=32, REG_ADDR_W=5, REG_ZERO=0; reused by decode and writeback.
- Sub-module `dff_register`: WIDTH-bit register of D_flip_flop instances with common clk, rst, enable; instantiated DEPTH−1 times (index 1..DEPTH−1).
- Top level holds the write decoder, two DEPTH:1 read muxes and optional bypass logic.

## Test plan
- Reset: rst=1 then 0, sweep A_addr/B_addr 0..31 -> all reads 0x00000000.
- Write/read: write 0xDEADBEEF to r5, then A_addr=5, B_addr=5 -> both 0xDEADBEEF; r4, r6 still 0.
- Zero register: write 0x12345678 to r0 -> A_addr=0 reads 0 after the edge, also 0 with BYPASS=1.
- Hold/same-cycle: r7=0x1; wr_enable=0, W_addr=7, W_data=0xFFFFFFFF -> r7 stays 0x1; with wr_enable=1 and A_addr=7, BYPASS=0 -> 0x1 before edge, 0xFFFFFFFF after; BYPASS=1 -> 0xFFFFFFFF before edge.
- Async reset mid-operation: fill r1..r31 with index value, pulse rst between edges -> all reads 0 immediately, write coincident with rst dropped.
- Back-to-back: write r1..r31 on consecutive edges with distinct data -> each read matches; no aliasing across registers.
